reg_file_sb: RTL
================

# reg_file_sb

Parametrised successor to the processor's 32×32 register bank: one write port, two combinational read ports, selectable hardwired-zero register, write-to-read bypass, a per-register pending scoreboard, and a valid/ready output-capture channel. Sits in the decode/execute boundary of the core. The datapath reads operands here, issue logic marks destinations pending, and the I/O unit drains register values through the output channel.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth is 2**ADDR_W
- `ZERO_REG`, 1, when 1 register 0 always reads 0 and ignores writes and busy_set
- `BYPASS`, 1, when 1 a same-cycle write is forwarded to the read and output ports
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `we`  in  1  write enable
- `waddr`  in  ADDR_W  write address
- `wdata`  in  DATA_W  write data
- `raddr_a`, `raddr_b`  in  ADDR_W  read addresses
- `rdata_a`, `rdata_b`  out  DATA_W  read data, combinational
- `busy_set`  in  1  mark `busy_addr` pending
- `busy_addr`  in  ADDR_W  register to mark pending
- `busy_a`, `busy_b`  out  1  pending status of `raddr_a`/`raddr_b`, combinational
- `out_req`  in  1  level request; a rising edge triggers a capture
- `out_addr`  in  ADDR_W  register to capture
- `out_data`  out  DATA_W  captured value, registered
- `out_valid`  out  1  `out_data` holds an unconsumed value
- `out_ready`  in  1  consumer accepts when `out_valid` is also high
- `out_overrun`  out  1  sticky; a capture request was dropped

## Operation
- **Reset, applied for one cycle.** All registers are 0, pending bits 0, `out_valid` 0, `out_data` 0, `out_overrun` 0, and the edge-detect flop is 0. Reset overrides every other input in that cycle.
- **Write.** `we` stores `wdata` at `waddr` and clears `pending[waddr]`. With `ZERO_REG=1`, a write to address 0 is discarded.
- **Read.** `rdata_x = mem[raddr_x]`, which is 0 for address 0 when `ZERO_REG=1`.
  - With `BYPASS=1`, if `we` is high and `waddr==raddr_x` and the write is not discarded, then `rdata_x = wdata`.
- **Scoreboard.**
  - `busy_set` sets `pending[busy_addr]`.
  - Set and write in the same cycle to the same address: the set wins, so the bit stays 1 because a new producer has been issued.
  - `busy_x = pending[raddr_x]`. With `BYPASS=1`, `busy_x` is also forced to 0 when a non-discarded write to `raddr_x` occurs this cycle.
  - Address 0 is never pending when `ZERO_REG=1`.
- **Output channel FSM**, states IDLE and HOLD.
  - `rise = out_req & ~out_req_q`.
  - IDLE, on `rise`: capture the read value of `out_addr` (same bypass rule as the read ports) into `out_data`, then go to HOLD.
  - HOLD, `out_valid & out_ready` without `rise`: go to IDLE. `out_data` keeps its last value.
  - HOLD, `rise` with `out_ready`: capture the new value and stay in HOLD (back-to-back).
  - HOLD, `rise` without `out_ready`: drop the request, set `out_overrun`, keep `out_data` unchanged.
  - `out_valid` is 1 exactly in HOLD.
- **Out-of-range addresses.** None are possible: depth is a power of two.

## Timing
- Reads and `busy_*`: zero latency, combinational.
- Write to a later read: visible at the next edge, or in the same cycle via bypass.
- `busy_set` at edge k: `busy_*` reads 1 after edge k.
- `out_req` first sampled high at edge k: `out_data`/`out_valid` update at edge k, so they are visible one cycle after `out_req` is asserted.
- Handshake completes at the edge where `out_valid & out_ready`; `out_valid` falls after that edge.
- `out_req` held high generates only one capture.
- Reset mid-HOLD: `out_valid` is 0 the next cycle and the pending value is lost.

## Structure
- Shared package `reg_file_pkg` holds:
  - `DATA_W`/`ADDR_W` defaults;
  - the `out_state_t` enum {IDLE, HOLD};
  - the read-with-bypass function, reused by both read ports and the capture path.
- One sub-module, `rise_detect`: one flop plus AND, with synchronous active-high reset.
- Storage is a flat array of registers, because reset must clear every entry.

## Test plan
- **Reset and zero register.** Reset, then write 0xDEADBEEF to r0 and 0x12345678 to r5; read both -> r0=0, r5=0x12345678, all `busy_*`=0, `out_valid`=0.
- **Bypass.** Write r7=0xA5A5A5A5 with `raddr_a`=7 in the same cycle -> `rdata_a`=0xA5A5A5A5 that cycle. Repeat with `BYPASS=0` -> `rdata_a` shows the old value 0.
- **Scoreboard.**
  - `busy_set` r3, then `raddr_b`=3 -> `busy_b`=1.
  - Write r3=0x1 -> `busy_b`=0 in the write cycle (BYPASS) and after.
  - Set and write r3 in the same cycle -> `busy_b`=1 after the edge.
- **Output handshake.** Set r9=0x55, pulse `out_req` with `out_addr`=9 and `out_ready`=0 -> `out_valid`=1 and `out_data`=0x55 after 1 cycle, held for 5 cycles. Raise `out_ready` -> `out_valid`=0 next cycle.
- **Overrun and back-to-back.**
  - In HOLD, a second rise with `out_ready`=0 -> `out_data` unchanged, `out_overrun`=1.
  - A rise with `out_ready`=1 -> new value captured, `out_valid` stays 1.
  - `out_req` held high for 10 cycles -> exactly one capture.
- **Reset mid-operation.** In HOLD with r4 pending, assert `rst` -> next cycle `out_valid`=0, `out_overrun`=0, `busy` for r4 = 0, r4 reads 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared definitions for the register bank with scoreboard:
//                default sizes, output-channel state encoding and the
//                read-source selection used by both read ports and the
//                output capture path.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 5;

   // Output channel states: HOLD means out_data carries an unconsumed value
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } out_state_t;

   // Where a read value comes from
   typedef enum logic [1:0] {
      SRC_MEM   = 2'd0,
      SRC_WDATA = 2'd1,
      SRC_ZERO  = 2'd2
   } rd_src_t;

   // Read-with-bypass selection. write_hit must already exclude discarded
   // writes (writes to the hardwired-zero register), so a zero register is
   // never bypassed.
   function automatic rd_src_t read_src(
      input logic bypass_en,
      input logic zero_en,
      input logic addr_is_zero,
      input logic write_hit
   );
      if (zero_en && addr_is_zero) begin
         return SRC_ZERO;
      end
      if (bypass_en && write_hit) begin
         return SRC_WDATA;
      end
      return SRC_MEM;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Rising-edge detector on a level request: one flop plus AND.
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   output logic o_rise
);

   logic r_req_q;

   // Remember the previous level of the request
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_q <= 1'b0;
      end else begin
         r_req_q <= i_req;
      end
   end

   assign o_rise = i_req & ~r_req_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb
//  Description : Register bank with one write port, two combinational read
//                ports, optional hardwired-zero register, write-to-read
//                bypass, per-register pending scoreboard and a valid/ready
//                output-capture channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = REG_DATA_W,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_addr,
   output logic              busy_a,
   output logic              busy_b,
   input  logic              out_req,
   input  logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_overrun
);

   localparam int   c_DEPTH     = 2 ** ADDR_W;
   localparam logic c_ZERO_EN   = (ZERO_REG != 0);
   localparam logic c_BYPASS_EN = (BYPASS != 0);

   logic [DATA_W-1:0]  r_mem [c_DEPTH];
   logic [c_DEPTH-1:0] r_pending;
   out_state_t         r_state;
   out_state_t         w_state_nxt;
   logic [DATA_W-1:0]  r_out_data;
   logic               r_overrun;

   logic    w_we_eff;
   logic    w_set_eff;
   logic    w_hit_a;
   logic    w_hit_b;
   logic    w_hit_o;
   rd_src_t w_src_a;
   rd_src_t w_src_b;
   rd_src_t w_src_o;
   logic [DATA_W-1:0] w_cap_data;
   logic    w_rise;
   logic    w_load;
   logic    w_ovr_set;

   // Writes and pending marks aimed at the hardwired-zero register are dropped
   assign w_we_eff  = we & ~(c_ZERO_EN && (waddr == '0));
   assign w_set_eff = busy_set & ~(c_ZERO_EN && (busy_addr == '0));

   assign w_hit_a = w_we_eff && (waddr == raddr_a);
   assign w_hit_b = w_we_eff && (waddr == raddr_b);
   assign w_hit_o = w_we_eff && (waddr == out_addr);

   assign w_src_a = read_src(c_BYPASS_EN, c_ZERO_EN, (raddr_a == '0), w_hit_a);
   assign w_src_b = read_src(c_BYPASS_EN, c_ZERO_EN, (raddr_b == '0), w_hit_b);
   assign w_src_o = read_src(c_BYPASS_EN, c_ZERO_EN, (out_addr == '0), w_hit_o);

   assign rdata_a = (w_src_a == SRC_ZERO)  ? '0 :
                    (w_src_a == SRC_WDATA) ? wdata : r_mem[raddr_a];
   assign rdata_b = (w_src_b == SRC_ZERO)  ? '0 :
                    (w_src_b == SRC_WDATA) ? wdata : r_mem[raddr_b];
   assign w_cap_data = (w_src_o == SRC_ZERO)  ? '0 :
                       (w_src_o == SRC_WDATA) ? wdata : r_mem[out_addr];

   // A same-cycle write retires the producer, so bypass also clears busy
   assign busy_a = r_pending[raddr_a] & ~(c_BYPASS_EN & w_hit_a);
   assign busy_b = r_pending[raddr_b] & ~(c_BYPASS_EN & w_hit_b);

   // Register storage; reset clears every entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_we_eff) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Pending scoreboard; a set is applied after the clear so it wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         if (w_we_eff) begin
            r_pending[waddr] <= 1'b0;
         end
         if (w_set_eff) begin
            r_pending[busy_addr] <= 1'b1;
         end
      end
   end

   rise_detect u_rise_detect (
      .clk    (clk),
      .rst    (rst),
      .i_req  (out_req),
      .o_rise (w_rise)
   );

   // Output channel state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output channel next state, capture strobe and overrun strobe
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ovr_set   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_load      = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (w_rise) begin
               if (out_ready) begin
                  w_load = 1'b1;
               end else begin
                  w_ovr_set = 1'b1;
               end
            end else if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Captured value and sticky overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data <= '0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_data <= w_cap_data;
         end
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign out_data    = r_out_data;
   assign out_valid   = (r_state == HOLD);
   assign out_overrun = r_overrun;

endmodule
`default_nettype wire
